// File: rtl/stack_program_sequencer.sv
// stack_program_sequencer: 16-word program store that feeds opcode/operand nibbles and reset
// to the 4-bit stack calculator core. Optional macro SEQ_LOOP_EN repeats the program until abort.
module stack_program_sequencer (
   input  logic       clk,
   input  logic       rst,
   input  logic       prog_we,
   input  logic [3:0] prog_addr,
   input  logic [7:0] prog_wdata,
   input  logic       start,
   input  logic       pause,
   input  logic       abort,
   output logic       cpu_rst,
   output logic [3:0] cpu_inbits,
   output logic       busy,
   output logic       done,
   output logic [3:0] pc,
   output logic [7:0] instr_count
);
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_RESET   = 3'd1;
   localparam logic [2:0] ST_FETCH   = 3'd2;
   localparam logic [2:0] ST_EXEC    = 3'd3;
   localparam logic [2:0] ST_PAUSE_F = 3'd4;
   localparam logic [2:0] ST_PAUSE_E = 3'd5;
   localparam logic [2:0] ST_DONE    = 3'd6;
   localparam logic [3:0] OP_HALT    = 4'hF;

   logic [2:0] state_q, state_d;
   logic [3:0] pc_q, pc_d;
   logic [7:0] cnt_q, cnt_d;
   logic [1:0] exec_left_q, exec_left_d;
   logic       cpu_rst_q, cpu_rst_d;
   logic [3:0] inbits_q, inbits_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic [7:0] mem_q [16];
   logic [7:0] mem_d [16];
   logic       bnd_en, bnd_wrap, halt;
   logic [3:0] bnd_pc, nxt_pc;

   function automatic logic [1:0] exec_len(input logic [3:0] op);
      case (op)
         4'h1, 4'h2, 4'h5, 4'h6, 4'h7, 4'h8: exec_len = 2'd2;
         4'h9, 4'hA:                         exec_len = 2'd3;
         default:                            exec_len = 2'd1;
      endcase
   endfunction

   always_comb begin
      mem_d = mem_q;
      if (prog_we && (state_q == ST_IDLE || state_q == ST_DONE))
         mem_d[prog_addr] = prog_wdata;
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      cnt_d       = cnt_q;
      exec_left_d = exec_left_q;
      cpu_rst_d   = 1'b0;
      inbits_d    = 4'h0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      bnd_en      = 1'b0;
      bnd_pc      = pc_q;
      bnd_wrap    = 1'b0;
      halt        = 1'b0;
      nxt_pc      = pc_q + 4'd1;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_RESET;
               pc_d    = 4'd0;
               cnt_d   = 8'd0;
            end
         end
         ST_RESET, ST_PAUSE_E: bnd_en = 1'b1;
         ST_FETCH: begin
            state_d     = ST_EXEC;
            exec_left_d = exec_len(mem_q[pc_q][3:0]) - 2'd1;
         end
         ST_EXEC: begin
            if (exec_left_q == 2'd0) begin
               bnd_en   = 1'b1;
               bnd_pc   = nxt_pc;
               bnd_wrap = (pc_q == 4'hF);
            end else begin
               exec_left_d = exec_left_q - 2'd1;
            end
         end
         ST_PAUSE_F: state_d = ST_PAUSE_E;
         default:    state_d = ST_IDLE;
      endcase

      // Instruction boundary: end of program, pause slot, or next fetch
      if (bnd_en) begin
         halt = (mem_q[bnd_pc][3:0] == OP_HALT) || bnd_wrap;
         pc_d = bnd_pc;
`ifdef SEQ_LOOP_EN
         if (halt) begin
            pc_d = 4'd0;
            if (mem_q[0][3:0] == OP_HALT) state_d = ST_DONE;
            else if (pause)               state_d = ST_PAUSE_F;
            else                          state_d = ST_FETCH;
         end else if (pause) begin
            state_d = ST_PAUSE_F;
         end else begin
            state_d = ST_FETCH;
         end
`else
         if (halt)       state_d = ST_DONE;
         else if (pause) state_d = ST_PAUSE_F;
         else            state_d = ST_FETCH;
`endif
      end

      if (abort) begin
         state_d     = ST_IDLE;
         pc_d        = pc_q;
         cnt_d       = cnt_q;
         exec_left_d = exec_left_q;
      end

      // Outputs are registered copies decoded from the state being entered
      cpu_rst_d = abort || (state_d == ST_RESET);
      case (state_d)
         ST_FETCH: begin
            inbits_d = mem_q[pc_d][3:0];
            cnt_d    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
         end
         ST_EXEC: inbits_d = mem_q[pc_d][7:4];
         default: inbits_d = 4'h0;
      endcase
      busy_d = (state_d == ST_RESET) || (state_d == ST_FETCH) || (state_d == ST_EXEC) ||
               (state_d == ST_PAUSE_F) || (state_d == ST_PAUSE_E);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         pc_q        <= 4'd0;
         cnt_q       <= 8'd0;
         exec_left_q <= 2'd0;
         cpu_rst_q   <= 1'b0;
         inbits_q    <= 4'h0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         for (int i = 0; i < 16; i++) mem_q[i] <= {4'h0, OP_HALT};
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         cnt_q       <= cnt_d;
         exec_left_q <= exec_left_d;
         cpu_rst_q   <= cpu_rst_d;
         inbits_q    <= inbits_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         for (int i = 0; i < 16; i++) mem_q[i] <= mem_d[i];
      end
   end

   assign cpu_rst     = cpu_rst_q;
   assign cpu_inbits  = inbits_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign pc          = pc_q;
   assign instr_count = cnt_q;
endmodule

// File: tb/tb_stack_program_sequencer.sv
// Bench for stack_program_sequencer: vector table, hand corner sequences and random programs
// checked against a program-level trace model (loop-mode section under SEQ_LOOP_EN).
module tb_stack_program_sequencer;
   logic       clk = 1'b0;
   logic       rst, prog_we, start, pause, abort;
   logic [3:0] prog_addr;
   logic [7:0] prog_wdata;
   logic       cpu_rst, busy, done;
   logic [3:0] cpu_inbits, pc;
   logic [7:0] instr_count;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic       rst;
      logic [3:0] inb;
      logic       busy;
      logic       done;
      logic [3:0] pc;
      logic [7:0] cnt;
   } outs_t;

   typedef struct {
      bit    start;
      bit    pause;
      bit    abort;
      outs_t exp;
   } vec_t;

   logic [7:0] prog [16];
   outs_t      trace [$];
   vec_t       tbl [26];

   stack_program_sequencer dut (
      .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
      .start(start), .pause(pause), .abort(abort), .cpu_rst(cpu_rst), .cpu_inbits(cpu_inbits),
      .busy(busy), .done(done), .pc(pc), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   function automatic outs_t mk(input logic r, input logic [3:0] i, input logic b,
                                input logic d, input logic [3:0] p, input logic [7:0] c);
      outs_t o;
      o.rst = r; o.inb = i; o.busy = b; o.done = d; o.pc = p; o.cnt = c;
      return o;
   endfunction

   function automatic vec_t v(input bit s, input bit p, input bit a, input outs_t e);
      vec_t x;
      x.start = s; x.pause = p; x.abort = a; x.exp = e;
      return x;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input outs_t e);
      outs_t g;
      g = mk(cpu_rst, cpu_inbits, busy, done, pc, instr_count);
      total++;
      if (g !== e) begin
         bad++;
         $display("FAIL %s: got rst=%0b inbits=%h busy=%0b done=%0b pc=%0d count=%0d, want rst=%0b inbits=%h busy=%0b done=%0b pc=%0d count=%0d",
                  name, g.rst, g.inb, g.busy, g.done, g.pc, g.cnt,
                  e.rst, e.inb, e.busy, e.done, e.pc, e.cnt);
      end
   endtask

   task automatic load_prog();
      for (int i = 0; i < 16; i++) begin
         prog_we = 1'b1; prog_addr = 4'(i); prog_wdata = prog[i];
         tick();
      end
      prog_we = 1'b0;
   endtask

   // Program-level model: walk the program, emitting one record per core cycle.
   task automatic build_trace();
      int         p, c, len;
      logic [3:0] op;
      trace.delete();
      p = 0; c = 0;
      trace.push_back(mk(1'b1, 4'h0, 1'b1, 1'b0, 4'd0, 8'd0));
      for (int n = 0; n < 16; n++) begin
         op = prog[p][3:0];
         if (op == 4'hF) break;
         if (c < 255) c++;
         trace.push_back(mk(1'b0, op, 1'b1, 1'b0, 4'(p), 8'(c)));
         if (op inside {4'h1, 4'h2, 4'h5, 4'h6, 4'h7, 4'h8}) len = 2;
         else if (op inside {4'h9, 4'hA})                    len = 3;
         else                                                len = 1;
         for (int k = 0; k < len; k++)
            trace.push_back(mk(1'b0, prog[p][7:4], 1'b1, 1'b0, 4'(p), 8'(c)));
         p = (p + 1) % 16;
      end
      trace.push_back(mk(1'b0, 4'h0, 1'b0, 1'b1, 4'(p), 8'(c)));
   endtask

   // wp: cycle index at which a protected write to address 5 is attempted (-1 = none)
   // sw: write prog[0] in the same cycle as start
   task automatic run_prog(input string name, input int wp, input bit sw);
      build_trace();
      start = 1'b1;
      if (sw) begin prog_we = 1'b1; prog_addr = 4'd0; prog_wdata = prog[0]; end
      tick();
      start = 1'b0; prog_we = 1'b0;
      check($sformatf("%s[0]", name), trace[0]);
      for (int i = 1; i < trace.size(); i++) begin
         prog_we = (i == wp); prog_addr = 4'd5; prog_wdata = 8'h0F;
         tick();
         check($sformatf("%s[%0d]", name, i), trace[i]);
      end
      prog_we = 1'b0;
      tick();
      check($sformatf("%s hold", name), trace[trace.size()-1]);
   endtask

   initial begin
      rst = 1'b1; prog_we = 1'b0; prog_addr = 4'h0; prog_wdata = 8'h00;
      start = 1'b0; pause = 1'b0; abort = 1'b0;
      tick(); tick();
      rst = 1'b0;
      check("reset state", mk(0, 4'h0, 0, 0, 4'd0, 8'd0));

`ifdef SEQ_LOOP_EN
      for (int i = 0; i < 16; i++) prog[i] = 8'h0F;
      prog[0] = 8'h12;
      load_prog();
      start = 1'b1; tick(); start = 1'b0;
      check("loop reset", mk(1, 4'h0, 1, 0, 4'd0, 8'd0));
      for (int i = 1; i <= 300; i++) begin
         tick();
         check($sformatf("loop fetch %0d", i), mk(0, 4'h2, 1, 0, 4'd0, (i > 255) ? 8'd255 : 8'(i)));
         for (int k = 0; k < 2; k++) begin
            tick();
            check($sformatf("loop exec %0d", i), mk(0, 4'h1, 1, 0, 4'd0, (i > 255) ? 8'd255 : 8'(i)));
         end
      end
      abort = 1'b1; tick(); abort = 1'b0;
      check("loop abort", mk(1, 4'h0, 0, 0, 4'd0, 8'd255));
      prog[0] = 8'h0F;
      load_prog();
      start = 1'b1; tick(); start = 1'b0;
      check("loop halt0 reset", mk(1, 4'h0, 1, 0, 4'd0, 8'd0));
      tick();
      check("loop halt0 done", mk(0, 4'h0, 0, 1, 4'd0, 8'd0));
`else
      tbl[0]  = v(1, 0, 0, mk(1, 4'h0, 1, 0, 4'd0, 8'd0));
      tbl[1]  = v(0, 0, 0, mk(0, 4'h1, 1, 0, 4'd0, 8'd1));
      tbl[2]  = v(0, 0, 0, mk(0, 4'h1, 1, 0, 4'd0, 8'd1));
      tbl[3]  = v(0, 0, 0, mk(0, 4'h1, 1, 0, 4'd0, 8'd1));
      tbl[4]  = v(0, 0, 0, mk(0, 4'h1, 1, 0, 4'd1, 8'd2));
      tbl[5]  = v(0, 0, 0, mk(0, 4'h5, 1, 0, 4'd1, 8'd2));
      tbl[6]  = v(0, 0, 0, mk(0, 4'h5, 1, 0, 4'd1, 8'd2));
      tbl[7]  = v(0, 0, 0, mk(0, 4'h8, 1, 0, 4'd2, 8'd3));
      tbl[8]  = v(0, 0, 0, mk(0, 4'h0, 1, 0, 4'd2, 8'd3));
      tbl[9]  = v(0, 0, 0, mk(0, 4'h0, 1, 0, 4'd2, 8'd3));
      tbl[10] = v(0, 0, 0, mk(0, 4'h3, 1, 0, 4'd3, 8'd4));
      tbl[11] = v(0, 0, 0, mk(0, 4'h0, 1, 0, 4'd3, 8'd4));
      tbl[12] = v(0, 0, 0, mk(0, 4'h0, 0, 1, 4'd4, 8'd4));
      tbl[13] = v(0, 0, 0, mk(0, 4'h0, 0, 1, 4'd4, 8'd4));
      tbl[14] = v(1, 0, 0, mk(1, 4'h0, 1, 0, 4'd0, 8'd0));
      tbl[15] = v(0, 0, 0, mk(0, 4'h1, 1, 0, 4'd0, 8'd1));
      tbl[16] = v(0, 0, 0, mk(0, 4'h1, 1, 0, 4'd0, 8'd1));
      tbl[17] = v(0, 0, 0, mk(0, 4'h1, 1, 0, 4'd0, 8'd1));
      tbl[18] = v(0, 1, 0, mk(0, 4'h0, 1, 0, 4'd1, 8'd1));
      tbl[19] = v(0, 1, 0, mk(0, 4'h0, 1, 0, 4'd1, 8'd1));
      tbl[20] = v(0, 1, 0, mk(0, 4'h0, 1, 0, 4'd1, 8'd1));
      tbl[21] = v(0, 0, 0, mk(0, 4'h0, 1, 0, 4'd1, 8'd1));
      tbl[22] = v(0, 0, 0, mk(0, 4'h1, 1, 0, 4'd1, 8'd2));
      tbl[23] = v(0, 0, 0, mk(0, 4'h5, 1, 0, 4'd1, 8'd2));
      tbl[24] = v(0, 0, 1, mk(1, 4'h0, 0, 0, 4'd1, 8'd2));
      tbl[25] = v(0, 0, 0, mk(0, 4'h0, 0, 0, 4'd1, 8'd2));

      for (int i = 0; i < 16; i++) prog[i] = 8'h0F;
      prog[0] = 8'h11; prog[1] = 8'h51; prog[2] = 8'h08; prog[3] = 8'h03;
      load_prog();
      for (int i = 0; i < 26; i++) begin
         start = tbl[i].start; pause = tbl[i].pause; abort = tbl[i].abort;
         tick();
         check($sformatf("table[%0d]", i), tbl[i].exp);
      end
      start = 1'b0; pause = 1'b0; abort = 1'b0;

      // Abort in the middle of a MULT execute
      for (int i = 0; i < 16; i++) prog[i] = 8'h0F;
      prog[0] = 8'h39; prog[1] = 8'h4A;
      load_prog();
      start = 1'b1; tick(); start = 1'b0;
      check("abort: reset", mk(1, 4'h0, 1, 0, 4'd0, 8'd0));
      tick(); check("abort: fetch", mk(0, 4'h9, 1, 0, 4'd0, 8'd1));
      tick(); check("abort: exec1", mk(0, 4'h3, 1, 0, 4'd0, 8'd1));
      abort = 1'b1; tick(); abort = 1'b0;
      check("abort: pulse", mk(1, 4'h0, 0, 0, 4'd0, 8'd1));
      tick(); check("abort: idle", mk(0, 4'h0, 0, 0, 4'd0, 8'd1));

      run_prog("longops", -1, 1'b0);

      // Full program without HALT; a write during the run must be ignored
      for (int i = 0; i < 16; i++) prog[i] = {4'(i), 4'(i % 15)};
      load_prog();
      run_prog("full16", 3, 1'b0);

      prog[0] = 8'h27;
      run_prog("start+write", -1, 1'b1);

      for (int r = 0; r < 20; r++) begin
         for (int i = 0; i < 16; i++) begin
            prog[i][7:4] = 4'($urandom_range(0, 15));
            prog[i][3:0] = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 14));
         end
         load_prog();
         run_prog($sformatf("rand%0d", r), -1, 1'b0);
      end
`endif

      // Reset restores the all-HALT memory
      rst = 1'b1; tick(); rst = 1'b0;
      check("rst clears", mk(0, 4'h0, 0, 0, 4'd0, 8'd0));
      for (int i = 0; i < 16; i++) prog[i] = 8'h0F;
      run_prog("after rst", -1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
